// File: rtl/hovalaag_run_ctrl.sv
// hovalaag_run_ctrl: run sequencer for a HOVALAAG-style CPU core.
//
// Holds the CPU in reset, feeds it from two 8 x 12-bit input FIFOs (IN1/IN2),
// collects its output events into a 4 x 13-bit output FIFO ({select, data}) and
// ends the run once the expected number of outputs has been produced, or on error.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   start, clr                    begin a run; flush all FIFOs (only when not busy)
//   expected_outputs, cycle_limit output events ending a run; RUN cycle budget
//   in1_*/in2_*                   input stream push side (wdata/wvalid/wready)
//   cpu_rst                       active-high CPU hold, low only in RUN
//   cpu_IN1/cpu_IN2, cpu_INx_adv  FIFO heads (zero when empty) and CPU consume strobes
//   cpu_OUT, cpu_OUT_valid/select CPU output events (select 0 = OUT1, 1 = OUT2)
//   out_data/out_sel/out_valid/out_ready  output drain (valid/ready)
//   busy, done, error, err_code, cycle_count  run status
//
// Optional build feature: define HOVALAAG_CTRL_TIMEOUT_EN to turn cycle_limit into a
// RUN timeout (err_code 2'b11). Without it cycle_limit is ignored.
//
// err_code: 2'b01 input underflow, 2'b10 output overflow, 2'b11 timeout.

module hovalaag_run_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clr,
    input  logic [7:0]  expected_outputs,
    input  logic [15:0] cycle_limit,
    input  logic [11:0] in1_wdata,
    input  logic        in1_wvalid,
    output logic        in1_wready,
    input  logic [11:0] in2_wdata,
    input  logic        in2_wvalid,
    output logic        in2_wready,
    output logic        cpu_rst,
    output logic [11:0] cpu_IN1,
    output logic [11:0] cpu_IN2,
    input  logic        cpu_IN1_adv,
    input  logic        cpu_IN2_adv,
    input  logic [11:0] cpu_OUT,
    input  logic        cpu_OUT_valid,
    input  logic        cpu_OUT_select,
    output logic [11:0] out_data,
    output logic        out_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] cycle_count
);

    localparam int unsigned InDepth  = 8;
    localparam int unsigned OutDepth = 4;

    localparam logic [1:0] ErrUnderflow = 2'b01;
    localparam logic [1:0] ErrOverflow  = 2'b10;
    localparam logic [1:0] ErrTimeout   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StRun,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic        hold_q, hold_d;
    logic [15:0] cyc_q, cyc_d;
    logic [7:0]  evt_q, evt_d;
    logic [1:0]  err_q, err_d;

    logic run;
    logic flush;

    assign run   = (state_q == StRun);
    // Flushing is only honoured while no run is in progress.
    assign flush = clr && (state_q != StHold) && (state_q != StRun);

    // ------------------------------------------------------------------------
    // IN1 FIFO
    // ------------------------------------------------------------------------
    logic [11:0] in1_mem [InDepth];
    logic [2:0]  in1_wp_q, in1_rp_q;
    logic [3:0]  in1_cnt_q;
    logic        in1_empty, in1_full, in1_push, in1_pop;

    assign in1_empty  = (in1_cnt_q == 4'd0);
    assign in1_full   = (in1_cnt_q == 4'(InDepth));
    assign in1_wready = !in1_full;
    assign in1_push   = in1_wvalid && !in1_full && !flush;
    assign in1_pop    = run && cpu_IN1_adv && !in1_empty;
    assign cpu_IN1    = in1_empty ? 12'h000 : in1_mem[in1_rp_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1_wp_q  <= '0;
            in1_rp_q  <= '0;
            in1_cnt_q <= '0;
        end else if (flush) begin
            in1_wp_q  <= '0;
            in1_rp_q  <= '0;
            in1_cnt_q <= '0;
        end else begin
            if (in1_push) in1_wp_q <= in1_wp_q + 3'd1;
            if (in1_pop)  in1_rp_q <= in1_rp_q + 3'd1;
            in1_cnt_q <= in1_cnt_q + 4'(in1_push) - 4'(in1_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (in1_push) in1_mem[in1_wp_q] <= in1_wdata;
    end

    // ------------------------------------------------------------------------
    // IN2 FIFO
    // ------------------------------------------------------------------------
    logic [11:0] in2_mem [InDepth];
    logic [2:0]  in2_wp_q, in2_rp_q;
    logic [3:0]  in2_cnt_q;
    logic        in2_empty, in2_full, in2_push, in2_pop;

    assign in2_empty  = (in2_cnt_q == 4'd0);
    assign in2_full   = (in2_cnt_q == 4'(InDepth));
    assign in2_wready = !in2_full;
    assign in2_push   = in2_wvalid && !in2_full && !flush;
    assign in2_pop    = run && cpu_IN2_adv && !in2_empty;
    assign cpu_IN2    = in2_empty ? 12'h000 : in2_mem[in2_rp_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in2_wp_q  <= '0;
            in2_rp_q  <= '0;
            in2_cnt_q <= '0;
        end else if (flush) begin
            in2_wp_q  <= '0;
            in2_rp_q  <= '0;
            in2_cnt_q <= '0;
        end else begin
            if (in2_push) in2_wp_q <= in2_wp_q + 3'd1;
            if (in2_pop)  in2_rp_q <= in2_rp_q + 3'd1;
            in2_cnt_q <= in2_cnt_q + 4'(in2_push) - 4'(in2_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (in2_push) in2_mem[in2_wp_q] <= in2_wdata;
    end

    // ------------------------------------------------------------------------
    // Output FIFO, entries are {select, data}
    // ------------------------------------------------------------------------
    logic [12:0] out_mem [OutDepth];
    logic [1:0]  out_wp_q, out_rp_q;
    logic [2:0]  out_cnt_q;
    logic        out_full, out_pop, out_try, out_push, out_space;
    logic [12:0] out_head;

    assign out_full  = (out_cnt_q == 3'(OutDepth));
    assign out_valid = (out_cnt_q != 3'd0);
    assign out_head  = out_mem[out_rp_q];
    assign out_data  = out_valid ? out_head[11:0] : 12'h000;
    assign out_sel   = out_valid ? out_head[12] : 1'b0;
    assign out_pop   = out_valid && out_ready;
    assign out_try   = run && cpu_OUT_valid;
    // A drain in the same cycle frees the slot before the push lands.
    assign out_space = !out_full || out_pop;
    assign out_push  = out_try && out_space;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
        end else if (flush) begin
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_push) out_wp_q <= out_wp_q + 2'd1;
            if (out_pop)  out_rp_q <= out_rp_q + 2'd1;
            out_cnt_q <= out_cnt_q + 3'(out_push) - 3'(out_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wp_q] <= {cpu_OUT_select, cpu_OUT};
    end

    // ------------------------------------------------------------------------
    // Run-ending conditions
    // ------------------------------------------------------------------------
    logic        underflow, overflow, timeout, completion;
    logic [15:0] cyc_inc;
    logic [7:0]  evt_inc;

    assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    assign evt_inc = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;

    assign underflow  = run && ((cpu_IN1_adv && in1_empty) || (cpu_IN2_adv && in2_empty));
    assign overflow   = out_try && !out_space;
    // Registered count is compared, so the run ends on the edge after the last output.
    assign completion = run && (evt_q >= expected_outputs);

`ifdef HOVALAAG_CTRL_TIMEOUT_EN
    // Fires in the RUN cycle whose increment brings cycle_count up to the limit.
    assign timeout = run && (cycle_limit != 16'd0) && (cyc_inc == cycle_limit);
`else
    logic unused_cycle_limit;
    assign unused_cycle_limit = ^cycle_limit;
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            hold_q  <= 1'b0;
            cyc_q   <= '0;
            evt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cyc_q   <= cyc_d;
            evt_q   <= evt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        evt_d   = evt_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StHold;
                    hold_d  = 1'b0;
                    cyc_d   = '0;
                    evt_d   = '0;
                    err_d   = '0;
                end
            end
            StHold: begin
                // hold_q marks the second HOLD cycle.
                if (hold_q) begin
                    state_d = StRun;
                    hold_d  = 1'b0;
                end else begin
                    hold_d = 1'b1;
                end
            end
            StRun: begin
                cyc_d = cyc_inc;
                if (out_push) evt_d = evt_inc;
                if (underflow) begin
                    state_d = StError;
                    err_d   = ErrUnderflow;
                end else if (overflow) begin
                    state_d = StError;
                    err_d   = ErrOverflow;
                end else if (timeout) begin
                    state_d = StError;
                    err_d   = ErrTimeout;
                end else if (completion) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cpu_rst     = (state_q != StRun);
    assign busy        = (state_q == StHold) || (state_q == StRun);
    assign done        = (state_q == StDone);
    assign error       = (state_q == StError);
    assign err_code    = err_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_hovalaag_run_ctrl.sv
// Scoreboard bench for hovalaag_run_ctrl: a behavioural CPU echoes input FIFO heads
// to its outputs; expected drain values come from the bench's own queues.
module tb_hovalaag_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clr;
    logic [7:0]  expected_outputs;
    logic [15:0] cycle_limit;
    logic [11:0] in1_wdata, in2_wdata;
    logic        in1_wvalid, in2_wvalid, in1_wready, in2_wready;
    logic        cpu_rst;
    logic [11:0] cpu_IN1, cpu_IN2;
    logic        cpu_IN1_adv, cpu_IN2_adv;
    logic [11:0] cpu_OUT;
    logic        cpu_OUT_valid, cpu_OUT_select;
    logic [11:0] out_data;
    logic        out_sel, out_valid, out_ready;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [15:0] cycle_count;

    always #5 clk = ~clk;

    hovalaag_run_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .clr              (clr),
        .expected_outputs (expected_outputs),
        .cycle_limit      (cycle_limit),
        .in1_wdata        (in1_wdata),
        .in1_wvalid       (in1_wvalid),
        .in1_wready       (in1_wready),
        .in2_wdata        (in2_wdata),
        .in2_wvalid       (in2_wvalid),
        .in2_wready       (in2_wready),
        .cpu_rst          (cpu_rst),
        .cpu_IN1          (cpu_IN1),
        .cpu_IN2          (cpu_IN2),
        .cpu_IN1_adv      (cpu_IN1_adv),
        .cpu_IN2_adv      (cpu_IN2_adv),
        .cpu_OUT          (cpu_OUT),
        .cpu_OUT_valid    (cpu_OUT_valid),
        .cpu_OUT_select   (cpu_OUT_select),
        .out_data         (out_data),
        .out_sel          (out_sel),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_code         (err_code),
        .cycle_count      (cycle_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the three FIFOs plus the source order of queued items.
    logic [11:0] in1_m [$];
    logic [11:0] in2_m [$];
    logic [12:0] exp_q [$];
    bit          src_q [$];
    logic [12:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every drain handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %0h expected none", {out_sel, out_data});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_sel, out_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL out_data: got %0h expected %0h", {out_sel, out_data}, mon_exp);
                end
            end
        end
    end

    task automatic push_in(input bit src, input logic [11:0] d);
        if (!src) begin
            if (in1_m.size() < 8) in1_m.push_back(d);
            in1_wdata = d; in1_wvalid = 1'b1;
        end else begin
            if (in2_m.size() < 8) in2_m.push_back(d);
            in2_wdata = d; in2_wvalid = 1'b1;
        end
        step();
        in1_wvalid = 1'b0; in2_wvalid = 1'b0;
    endtask

    // mode 0: IN1 only, 1: random source, 2: IN2 only
    task automatic load(input int n, input int mode);
        bit s;
        for (int i = 0; i < n; i++) begin
            s = (mode == 0) ? 1'b0 : (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            src_q.push_back(s);
            push_in(s, 12'($urandom));
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        in1_m.delete(); in2_m.delete(); exp_q.delete(); src_q.delete();
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        check("hold1_busy", 32'(busy), 32'd1);
        check("hold1_cpu_rst", 32'(cpu_rst), 32'd1);
        step();
        check("hold2_cpu_rst", 32'(cpu_rst), 32'd1);
        step();
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("run_cycle_start", 32'(cycle_count), 32'd0);
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 40) begin
            step();
            b++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_echo(input int n);
        int gaps = 0;
        int g;
        bit s;
        expected_outputs = 8'(n);
        cycle_limit = 16'd0;
        out_ready = 1'b1;
        start_run();
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, 2);
            repeat (g) step();
            gaps += g;
            s = src_q.pop_front();
            if (s) begin
                check("cpu_in2_head", 32'(cpu_IN2), 32'(in2_m[0]));
                cpu_IN2_adv = 1'b1;
                cpu_OUT = cpu_IN2;
                exp_q.push_back({1'b1, in2_m.pop_front()});
            end else begin
                check("cpu_in1_head", 32'(cpu_IN1), 32'(in1_m[0]));
                cpu_IN1_adv = 1'b1;
                cpu_OUT = cpu_IN1;
                exp_q.push_back({1'b0, in1_m.pop_front()});
            end
            cpu_OUT_select = s;
            cpu_OUT_valid = 1'b1;
            step();
            cpu_IN1_adv = 1'b0; cpu_IN2_adv = 1'b0; cpu_OUT_valid = 1'b0;
        end
        check("done_pending", 32'(done), 32'd0);
        step();
        check("done", 32'(done), 32'd1);
        check("done_error", 32'(error), 32'd0);
        check("done_err_code", 32'(err_code), 32'd0);
        check("done_cpu_rst", 32'(cpu_rst), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_cycles", 32'(cycle_count), 32'(gaps + n + 1));
        drain();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_cpu_in1"}, 32'(cpu_IN1), 32'd0);
        check({tag, "_in1_wready"}, 32'(in1_wready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; clr = 1'b0;
        expected_outputs = 8'd0; cycle_limit = 16'd0;
        in1_wdata = '0; in2_wdata = '0; in1_wvalid = 1'b0; in2_wvalid = 1'b0;
        cpu_IN1_adv = 1'b0; cpu_IN2_adv = 1'b0;
        cpu_OUT = '0; cpu_OUT_valid = 1'b0; cpu_OUT_select = 1'b0;
        out_ready = 1'b0;
        #1;
        reset_checks("reset");
        step();
        step();
        rst = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Three IN1 values echoed to OUT1.
        load(3, 0);
        run_echo(3);

        // expected_outputs = 0 finishes after the first RUN cycle.
        expected_outputs = 8'd0;
        start_run();
        step();
        check("zero_done", 32'(done), 32'd1);
        check("zero_cycles", 32'(cycle_count), 32'd1);

        // Randomized echo runs over both inputs.
        for (int r = 0; r < 5; r++) begin
            load($urandom_range(1, 8), 1);
            run_echo(src_q.size());
        end

        // Underflow: consume from empty IN1.
        do_clr();
        expected_outputs = 8'd5;
        start_run();
        check("empty_in1_head", 32'(cpu_IN1), 32'd0);
        cpu_IN1_adv = 1'b1;
        step();
        cpu_IN1_adv = 1'b0;
        check("uf_error", 32'(error), 32'd1);
        check("uf_err_code", 32'(err_code), 32'd1);
        check("uf_cpu_rst", 32'(cpu_rst), 32'd1);
        check("uf_cycles", 32'(cycle_count), 32'd1);
        step();
        check("uf_err_hold", 32'(err_code), 32'd1);

        // Overflow with a simultaneous drain that frees space first.
        expected_outputs = 8'd20;
        out_ready = 1'b0;
        start_run();
        for (int i = 0; i < 5; i++) begin
            cpu_OUT = 12'($urandom);
            cpu_OUT_select = 1'($urandom_range(0, 1));
            cpu_OUT_valid = 1'b1;
            exp_q.push_back({cpu_OUT_select, cpu_OUT});
            if (i == 4) out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        cpu_OUT_valid = 1'b0;
        check("of_pop_frees", 32'(error), 32'd0);
        check("of_full_valid", 32'(out_valid), 32'd1);
        cpu_OUT = 12'($urandom);
        cpu_OUT_valid = 1'b1;
        step();
        cpu_OUT_valid = 1'b0;
        check("of_error", 32'(error), 32'd1);
        check("of_err_code", 32'(err_code), 32'd2);
        check("of_cycles", 32'(cycle_count), 32'd6);
        out_ready = 1'b1;
        drain();
        step();
        check("of_drained", 32'(out_valid), 32'd0);

        // Nine pushes into IN2: the ninth is dropped.
        do_clr();
        for (int i = 0; i < 9; i++) begin
            check("in2_wready", 32'(in2_wready), 32'(in2_m.size() < 8));
            push_in(1'b1, 12'($urandom));
        end
        check("in2_full", 32'(in2_wready), 32'd0);
        for (int i = 0; i < 8; i++) src_q.push_back(1'b1);
        run_echo(8);
        check("in2_empty_after", 32'(cpu_IN2), 32'd0);

        // Timeout behaviour depends on the build option.
        expected_outputs = 8'd5;
        cycle_limit = 16'd10;
        out_ready = 1'b1;
        start_run();
`ifdef HOVALAAG_CTRL_TIMEOUT_EN
        repeat (9) step();
        check("to_not_yet", 32'(error), 32'd0);
        step();
        check("to_error", 32'(error), 32'd1);
        check("to_err_code", 32'(err_code), 32'd3);
        check("to_cycles", 32'(cycle_count), 32'd10);
`else
        repeat (30) step();
        check("noto_error", 32'(error), 32'd0);
        check("noto_busy", 32'(busy), 32'd1);
        check("noto_cycles", 32'(cycle_count), 32'd30);
        rst = 1'b0;
        #1;
        reset_checks("noto_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
`endif
        cycle_limit = 16'd0;

        // Reset in the middle of a run with buffered data.
        load(2, 0);
        src_q.delete();
        out_ready = 1'b0;
        start_run();
        check("mid_in1_head", 32'(cpu_IN1), 32'(in1_m[0]));
        cpu_OUT = 12'h5A5;
        cpu_OUT_valid = 1'b1;
        step();
        cpu_OUT_valid = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        reset_checks("mid_rst");
        in1_m.delete(); in2_m.delete(); exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in1", 32'(cpu_IN1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hovalaag_run_ctrl.md
HOVALAAG_RUN_CTRL -- requirements
Module: hovalaag_run_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: start  in  1  begin run pulse; clr  in  1  flush all FIFOs (IDLE/DONE/ERROR only).
REQ-003 SHALL have ports: expected_outputs  in  8  CPU output events ending a run; cycle_limit  in  16  max RUN cycles.
REQ-004 SHALL have ports: in1_wdata/in2_wdata  in  12  stream data; in1_wvalid/in2_wvalid  in  1  push; in1_wready/in2_wready  out  1  FIFO not full.
REQ-005 SHALL have ports: cpu_rst  out  1  active-high CPU hold; cpu_IN1/cpu_IN2  out  12  FIFO heads; cpu_IN1_adv/cpu_IN2_adv  in  1  CPU consume.
REQ-006 SHALL have ports: cpu_OUT  in  12; cpu_OUT_valid  in  1; cpu_OUT_select  in  1  (0=OUT1, 1=OUT2).
REQ-007 SHALL have ports: out_data  out  12; out_sel  out  1; out_valid  out  1; out_ready  in  1  (valid/ready drain).
REQ-008 SHALL have ports: busy, done, error  out  1; err_code  out  2; cycle_count  out  16.

Function
REQ-009 SHALL implement states IDLE, HOLD (2 cycles), RUN, DONE, ERROR.
REQ-010 SHALL assert cpu_rst in every state except RUN; busy=1 in HOLD and RUN only.
REQ-011 start in IDLE/DONE/ERROR SHALL go to HOLD, clearing cycle_count, output-event count, done, error, err_code; input FIFOs kept; start in HOLD/RUN ignored.
REQ-012 HOLD SHALL last exactly 2 cycles, then RUN; cpu_rst deasserts the first RUN cycle.
REQ-013 Input FIFOs SHALL be 8 deep x 12 bit each; push when wvalid && wready; write while full dropped.
REQ-014 cpu_INx SHALL equal FIFO head combinationally, 12'h000 when empty; cpu_INx_adv in RUN with non-empty FIFO pops 1 entry.
REQ-015 cpu_INx_adv in RUN with empty FIFO SHALL go to ERROR, err_code=2'b01 (underflow).
REQ-016 Each cycle with cpu_OUT_valid=1 in RUN SHALL push {cpu_OUT_select,cpu_OUT} into 4-deep output FIFO and increment event count.
REQ-017 Push into full output FIFO SHALL go to ERROR, err_code=2'b10 (overflow), data dropped; a pop the same cycle frees space first (no error).
REQ-018 out_valid SHALL be FIFO not-empty; out_data/out_sel the head; pop on out_valid && out_ready in any state.
REQ-019 When event count reaches expected_outputs, RUN SHALL go to DONE next edge, done=1; expected_outputs=0 goes to DONE on first RUN cycle.
REQ-020 cycle_count SHALL increment each RUN cycle, saturate at 16'hFFFF, hold value outside RUN.
REQ-021 Same-cycle priority: underflow > overflow > timeout > completion.
REQ-022 clr SHALL empty all three FIFOs in one cycle; clr during HOLD/RUN ignored.
REQ-023 done, error, err_code SHALL hold until next start or reset.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, empty FIFOs, cpu_rst=1, busy=done=error=0, err_code=0, cycle_count=0, out_valid=0.
REQ-025 Reset mid-RUN SHALL discard all data; first edge after rst high remains in IDLE.

Configuration
REQ-026 With HOVALAAG_CTRL_TIMEOUT_EN defined, cycle_count reaching cycle_limit in RUN SHALL go to ERROR, err_code=2'b11; cycle_limit=0 disables.
REQ-027 Without HOVALAAG_CTRL_TIMEOUT_EN, cycle_limit SHALL be ignored, no timeout; err_code 2'b11 never produced.

Verification
REQ-028 Push 3 values to IN1, expected_outputs=3, CPU model echoes IN1->OUT1, out_ready=1 -> 3 outputs in order, out_sel=0, done=1, cpu_rst=1.
REQ-029 IN1 empty, CPU asserts cpu_IN1_adv in RUN -> error=1, err_code=01, cpu_rst=1 next cycle.
REQ-030 out_ready=0, CPU emits 5 outputs -> 4 buffered, 5th gives err_code=10; out_ready=1 then drains 4.
REQ-031 TIMEOUT_EN, cycle_limit=10, no outputs -> ERROR after 10 RUN cycles, cycle_count=10; without macro, runs on.
REQ-032 9 pushes to IN2 -> 9th dropped, in2_wready=0 after 8; rst low mid-RUN -> all outputs at reset values immediately.
